redundancy_scanner: RTL and testbench

REDUNDANCY_SCANNER -- requirements
Module: redundancy_scanner

---
 rtl/redundancy_scanner_pkg.sv | 20 ++
 rtl/weight_buffer.sv | 35 +++
 rtl/redundancy_scanner.sv | 170 +++++++++++++++++
 tb/tb_redundancy_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/redundancy_scanner_pkg.sv
// Shared definitions for the redundancy scanner.
//   WORD_WIDTH  default weight / index width
//   MAX_C_SIZE  default maximum lowered-filter length in words
//   DIST_WIDTH  width of the downstream distance result
//   state_e     scanner FSM state encoding
package redundancy_scanner_pkg;

  localparam int unsigned WORD_WIDTH = 8;
  localparam int unsigned MAX_C_SIZE = 128;
  localparam int unsigned DIST_WIDTH = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StEmit,
    StDone
  } state_e;

endpackage

// File: rtl/weight_buffer.sv
// Weight store for one lowered filter: DEPTH x WORD_WIDTH, one synchronous
// write port and two asynchronous read ports (one for i, one for j).
// Ports:
//   clk                   clock
//   wr_en/wr_addr/wr_data write port
//   rd_i_addr/rd_i_data   asynchronous read port for index i
//   rd_j_addr/rd_j_data   asynchronous read port for index j
// Contents are not reset; the owner tracks how many entries are valid.
module weight_buffer #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_i_addr,
  output logic [WORD_WIDTH-1:0] rd_i_data,
  input  logic [ADDR_WIDTH-1:0] rd_j_addr,
  output logic [WORD_WIDTH-1:0] rd_j_data
);

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_i_data = mem[rd_i_addr];
  assign rd_j_data = mem[rd_j_addr];

endmodule

// File: rtl/redundancy_scanner.sv
// Redundancy scanner: loads one lowered filter, then for every index j finds
// the nearest earlier index i holding the same non-zero weight and presents
// (i, j) to the distance calculator over a valid/ready handshake.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   w_valid/w_ready       weight word handshake (w_ready only high while loading)
//   w_data, w_last        weight value in index order, last-word marker
//   pair_valid/pair_ready redundant pair handshake to the distance calculator
//   idx1, idx2            smaller / larger index of the redundant pair
//   done                  one-cycle pulse when a filter scan completes
module redundancy_scanner #(
  parameter int unsigned WORD_WIDTH = redundancy_scanner_pkg::WORD_WIDTH,
  parameter int unsigned MAX_C_SIZE = redundancy_scanner_pkg::MAX_C_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [WORD_WIDTH-1:0] w_data,
  input  logic                  w_last,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [WORD_WIDTH-1:0] idx1,
  output logic [WORD_WIDTH-1:0] idx2,
  output logic                  done
);

  import redundancy_scanner_pkg::*;

  localparam int unsigned AddrWidth = $clog2(MAX_C_SIZE);
  // One extra bit so a completely full buffer length is representable.
  localparam int unsigned LenWidth  = WORD_WIDTH + 1;

  state_e                state_q, state_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [WORD_WIDTH-1:0] i_q, i_d;
  logic [WORD_WIDTH-1:0] j_q, j_d;
  logic [WORD_WIDTH-1:0] idx1_q, idx1_d;
  logic [WORD_WIDTH-1:0] idx2_q, idx2_d;
  logic                  pair_valid_q, pair_valid_d;
  logic                  done_q, done_d;
  logic                  w_ready_q, w_ready_d;

  logic                  wr_en;
  logic                  beat;
  logic [WORD_WIDTH-1:0] buf_i;
  logic [WORD_WIDTH-1:0] buf_j;

  weight_buffer #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (MAX_C_SIZE),
    .ADDR_WIDTH (AddrWidth)
  ) u_weight_buffer (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (len_q[AddrWidth-1:0]),
    .wr_data   (w_data),
    .rd_i_addr (i_q[AddrWidth-1:0]),
    .rd_i_data (buf_i),
    .rd_j_addr (j_q[AddrWidth-1:0]),
    .rd_j_data (buf_j)
  );

  assign beat = w_valid && w_ready_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    i_d          = i_q;
    j_d          = j_q;
    idx1_d       = idx1_q;
    idx2_d       = idx2_q;
    pair_valid_d = pair_valid_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StLoad;
      end

      StLoad: begin
        if (beat) begin
          wr_en = !reset;
          len_d = len_q + LenWidth'(1);
          // The beat that fills the buffer ends loading just like w_last.
          if (w_last || (len_q == LenWidth'(MAX_C_SIZE - 1))) begin
            state_d = StScan;
            j_d     = WORD_WIDTH'(1);
            i_d     = '0;
          end
        end
      end

      StScan: begin
        if ({1'b0, j_q} == len_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (buf_j == '0) begin
          // Zero weights are never redundant; move on to the next j at once.
          j_d = j_q + WORD_WIDTH'(1);
          i_d = j_q;
        end else if (buf_i == buf_j) begin
          // buf_j is non-zero here, so a zero at i can never match.
          state_d      = StEmit;
          idx1_d       = i_q;
          idx2_d       = j_q;
          pair_valid_d = 1'b1;
        end else if (i_q == '0) begin
          j_d = j_q + WORD_WIDTH'(1);
          i_d = j_q;
        end else begin
          i_d = i_q - WORD_WIDTH'(1);
        end
      end

      StEmit: begin
        if (pair_ready) begin
          state_d      = StScan;
          pair_valid_d = 1'b0;
          j_d          = j_q + WORD_WIDTH'(1);
          i_d          = j_q;
        end
      end

      StDone: begin
        state_d = StIdle;
        len_d   = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered ready: high exactly while the FSM sits in LOAD.
    w_ready_d = (state_d == StLoad);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      i_q          <= '0;
      j_q          <= '0;
      idx1_q       <= '0;
      idx2_q       <= '0;
      pair_valid_q <= 1'b0;
      done_q       <= 1'b0;
      w_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      i_q          <= i_d;
      j_q          <= j_d;
      idx1_q       <= idx1_d;
      idx2_q       <= idx2_d;
      pair_valid_q <= pair_valid_d;
      done_q       <= done_d;
      w_ready_q    <= w_ready_d;
    end
  end

  assign w_ready    = w_ready_q;
  assign pair_valid = pair_valid_q;
  assign idx1       = idx1_q;
  assign idx2       = idx2_q;
  assign done       = done_q;

endmodule

// File: tb/tb_redundancy_scanner.sv
// Directed self-checking bench for redundancy_scanner.
module tb_redundancy_scanner;
  import redundancy_scanner_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] w_data;
  logic       w_last;
  logic       pair_valid;
  logic       pair_ready;
  logic [7:0] idx1;
  logic [7:0] idx2;
  logic       done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int acc;
  int dc;
  logic [15:0] pairs[$];
  logic [7:0]  vec[$];

  always #5 clk = ~clk;

  redundancy_scanner #(
    .WORD_WIDTH (8),
    .MAX_C_SIZE (128)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_last     (w_last),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .idx1       (idx1),
    .idx2       (idx2),
    .done       (done)
  );

  // Record every completed pair handshake and every done cycle.
  always @(posedge clk) begin
    if (!reset) begin
      if (pair_valid && pair_ready) pairs.push_back({idx1, idx2});
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!w_ready && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(w_ready), 1);
  endtask

  task automatic wait_pair(input string tag);
    int n;
    n = 0;
    while (!pair_valid && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(pair_valid), 1);
  endtask

  task automatic load_vec(input string tag);
    wait_ready(tag);
    for (int k = 0; k < vec.size(); k++) begin
      w_valid = 1'b1;
      w_data  = vec[k];
      w_last  = (k == vec.size() - 1);
      tick();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_data  = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_cnt"}, done_cnt - start, 1);
    check({tag, "_done_low"}, 32'(done), 0);
  endtask

  task automatic check_pairs(input string tag, input int n, input logic [15:0] e0,
                             input logic [15:0] e1);
    check({tag, "_npairs"}, pairs.size(), n);
    if (n > 0) check({tag, "_pair0"}, 32'(pairs.size() > 0 ? pairs[0] : 16'hffff), 32'(e0));
    if (n > 1) check({tag, "_pair1"}, 32'(pairs.size() > 1 ? pairs[1] : 16'hffff), 32'(e1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    w_valid    = 1'b0;
    w_data     = '0;
    w_last     = 1'b0;
    pair_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_pair_valid", 32'(pair_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_w_ready", 32'(w_ready), 0);
    check("rst_idx", 32'({idx1, idx2}), 0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b0;
    tick();
    check("release_w_ready", 32'(w_ready), 1);

    // [3,5,3,5] -> (0,2), (1,3)
    pairs.delete();
    vec = '{8'd3, 8'd5, 8'd3, 8'd5};
    load_vec("a_ready");
    wait_done("a", 300);
    check_pairs("a", 2, {8'd0, 8'd2}, {8'd1, 8'd3});

    // [7,7,7] -> nearest earlier only
    pairs.delete();
    vec = '{8'd7, 8'd7, 8'd7};
    load_vec("b_ready");
    wait_done("b", 300);
    check_pairs("b", 2, {8'd0, 8'd1}, {8'd1, 8'd2});

    // Zeros never pair
    pairs.delete();
    vec = '{8'd0, 8'd0, 8'd4, 8'd9};
    load_vec("c_ready");
    wait_done("c", 300);
    check_pairs("c", 0, 16'h0, 16'h0);

    // Single word
    pairs.delete();
    vec = '{8'd5};
    load_vec("d_ready");
    wait_done("d", 300);
    check_pairs("d", 0, 16'h0, 16'h0);

    // Backpressure: pair held stable while pair_ready is low
    pairs.delete();
    pair_ready = 1'b0;
    vec = '{8'd2, 8'd2};
    load_vec("e_ready");
    wait_pair("e_valid");
    for (int k = 0; k < 10; k++) begin
      tick();
      check("e_hold", 32'({pair_valid, idx1, idx2}), 32'({1'b1, 8'd0, 8'd1}));
    end
    pair_ready = 1'b1;
    tick();
    check("e_drop", 32'(pair_valid), 0);
    wait_done("e", 300);
    check_pairs("e", 1, {8'd0, 8'd1}, 16'h0);

    // 130 words without w_last: only 128 accepted; index 127 duplicates index 0
    pairs.delete();
    wait_ready("f_ready");
    acc = 0;
    for (int k = 0; k < 130; k++) begin
      w_valid = 1'b1;
      w_data  = (k == 127) ? 8'd1 : 8'(k + 1);
      w_last  = 1'b0;
      if (w_ready) acc++;
      tick();
    end
    w_valid = 1'b0;
    w_data  = '0;
    check("f_accepted", acc, 128);
    check("f_ready_low", 32'(w_ready), 0);
    check("f_state_scan", 32'(dut.state_q), 32'(StScan));
    wait_done("f", 20000);
    check_pairs("f", 1, {8'd0, 8'd127}, 16'h0);

    // Reset while a pair is pending
    pairs.delete();
    pair_ready = 1'b0;
    vec = '{8'd4, 8'd1, 8'd4};
    load_vec("g_ready");
    wait_pair("g_valid");
    check("g_pending", 32'({idx1, idx2}), 32'({8'd0, 8'd2}));
    dc = done_cnt;
    reset = 1'b1;
    tick();
    check("g_rst_pair_valid", 32'(pair_valid), 0);
    check("g_rst_done", 32'(done), 0);
    check("g_rst_state", 32'(dut.state_q), 32'(StIdle));
    check("g_rst_w_ready", 32'(w_ready), 0);
    reset = 1'b0;
    pair_ready = 1'b1;
    check("g_no_done", done_cnt - dc, 0);
    vec = '{8'd1, 8'd1};
    load_vec("g2_ready");
    wait_done("g2", 300);
    check_pairs("g2", 1, {8'd0, 8'd1}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
